// File: rtl/cplx_unit_arbiter.sv
// ---------------------------------------------------------------------------
// cplx_unit_arbiter
//
// Shares one pipelined, in-order complex arithmetic unit (complex_mul or
// complex_div) between NUM_REQ requesters. Requests are granted round-robin,
// the grant is held while the unit back-pressures, and every issued request's
// requester index is pushed into an in-order tag FIFO. Each unit result is
// routed back to the requester at the FIFO head.
//
// Parameters
//   NUM_REQ  number of requesters (>= 2)
//   DEPTH    maximum outstanding operations / tag FIFO depth (power of two, >= 2)
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_operands_i     per-requester operands {b2,a2,b1,a1}
//   req_valid_i        per-requester request valid
//   req_ready_o        request accepted (one-hot or zero)
//   rsp_result_o       shared result bus {b,a} (mirrors unit_result_i)
//   rsp_valid_o        result valid for the owning requester (one-hot or zero)
//   rsp_ready_i        per-requester result ready
//   unit_operands_o    operands of the granted requester
//   unit_in_valid_o    issue valid to the unit
//   unit_in_ready_i    unit accepts the issue
//   unit_result_i      unit result {b,a}
//   unit_out_valid_i   unit result valid
//   unit_out_ready_o   result ready to the unit
//   flush_i            synchronous flush
//   unit_flush_o       flush forwarded to the unit
//   outstanding_o      tag FIFO occupancy
//   orphan_o           sticky: a result arrived with no outstanding tag
//   busy_o             operations outstanding or an issue pending
// ---------------------------------------------------------------------------
module cplx_unit_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,

    input  logic [NUM_REQ-1:0][3:0][63:0]    req_operands_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,

    output logic [1:0][63:0]                 rsp_result_o,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    input  logic [NUM_REQ-1:0]               rsp_ready_i,

    output logic [3:0][63:0]                 unit_operands_o,
    output logic                             unit_in_valid_o,
    input  logic                             unit_in_ready_i,
    input  logic [1:0][63:0]                 unit_result_i,
    input  logic                             unit_out_valid_i,
    output logic                             unit_out_ready_o,

    input  logic                             flush_i,
    output logic                             unit_flush_o,
    output logic [$clog2(DEPTH):0]           outstanding_o,
    output logic                             orphan_o,
    output logic                             busy_o
);

    localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = TAG_W + 1;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Arbitration state
    logic [TAG_W-1:0] rr_ptr_q,   rr_ptr_d;
    logic             locked_q,   locked_d;
    logic [TAG_W-1:0] lock_idx_q, lock_idx_d;

    // Tag FIFO state
    logic [DEPTH-1:0][TAG_W-1:0] tag_mem_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             orphan_q, orphan_d;

    // Combinational intermediates
    logic             scan_found;
    logic [TAG_W-1:0] scan_idx;
    logic             grant_valid;
    logic [TAG_W-1:0] grant_idx;
    logic             fifo_full;
    logic             fifo_empty;
    logic             issue_fire;
    logic [TAG_W-1:0] head_tag;
    logic             pop_fire;
    logic             orphan_hit;

    // Round-robin scan: first valid requester starting at rr_ptr_q, wrapping mod NUM_REQ.
    always_comb begin
        logic [SUM_W-1:0] cand;
        scan_found = 1'b0;
        scan_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = SUM_W'(rr_ptr_q) + SUM_W'(k);
            if (cand >= SUM_W'(NUM_REQ)) begin
                cand = cand - SUM_W'(NUM_REQ);
            end
            if (!scan_found && req_valid_i[cand[TAG_W-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = cand[TAG_W-1:0];
            end
        end
    end

    // A held lock overrides the scan; the lock survives a dropped valid until flush.
    assign grant_valid = locked_q | scan_found;
    assign grant_idx   = locked_q ? lock_idx_q : scan_idx;

    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Issue side. A full FIFO blocks issue even when a pop happens in the same
    // cycle, so unit_out_valid_i never reaches unit_in_valid_o combinationally.
    assign unit_in_valid_o = grant_valid & ~fifo_full & ~flush_i;
    assign unit_operands_o = req_operands_i[grant_idx];
    assign issue_fire      = unit_in_valid_o & unit_in_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (issue_fire) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Return side: the FIFO head owns the current unit result.
    assign head_tag = tag_mem_q[rd_ptr_q];

    always_comb begin
        rsp_valid_o      = '0;
        unit_out_ready_o = 1'b1;
        if (!fifo_empty) begin
            unit_out_ready_o = rsp_ready_i[head_tag];
            if (!flush_i) begin
                rsp_valid_o[head_tag] = unit_out_valid_i;
            end
        end
    end

    assign pop_fire   = ~fifo_empty & unit_out_valid_i & rsp_ready_i[head_tag];
    assign orphan_hit =  fifo_empty & unit_out_valid_i;

    assign rsp_result_o  = unit_result_i;
    assign unit_flush_o  = flush_i;
    assign outstanding_o = count_q;
    assign orphan_o      = orphan_q;
    assign busy_o        = ~fifo_empty | unit_in_valid_o;

    // Next-state logic; flush has the highest priority.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        locked_d   = locked_q;
        lock_idx_d = lock_idx_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        orphan_d   = orphan_q | orphan_hit;

        if (issue_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            locked_d = 1'b0;
            if (grant_idx == TAG_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + TAG_W'(1);
            end
        end else if (unit_in_valid_o) begin
            locked_d   = 1'b1;
            lock_idx_d = grant_idx;
        end

        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({issue_fire, pop_fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush_i) begin
            rr_ptr_d = '0;
            locked_d = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            orphan_d = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q   <= '0;
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            orphan_q   <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            locked_q   <= locked_d;
            lock_idx_q <= lock_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            orphan_q   <= orphan_d;
        end
    end

    // Tag storage; contents are only read while count_q is non-zero.
    always_ff @(posedge clk_i) begin
        if (issue_fire) begin
            tag_mem_q[wr_ptr_q] <= grant_idx;
        end
    end

endmodule
